// File: rtl/txn_sequencer_if.sv
// rtl/txn_sequencer_if.sv - button/status bundle between the board and the game control FSM
interface txn_sequencer_if #(
   parameter int NUM_FIELDS = 3,
   parameter int FIELD_W    = 2
);
   logic                  abort_n;
   logic                  start_signal;
   logic                  load_signal;
   logic                  done_table_init;
   logic                  finished_init;
   logic                  finished_transaction;
   logic                  random_init;
   logic                  init_memory;
   logic                  load_memory;
   logic [NUM_FIELDS-1:0] load_field;
   logic [FIELD_W-1:0]    field_idx;
   logic                  start_transaction;
   logic                  reset_others_n;
   logic                  global_reset_n;
   logic                  txn_timeout;
   logic [3:0]            state_code;

   modport master (
      output abort_n, start_signal, load_signal, done_table_init, finished_init,
             finished_transaction,
      input  random_init, init_memory, load_memory, load_field, field_idx,
             start_transaction, reset_others_n, global_reset_n, txn_timeout, state_code
   );

   modport slave (
      input  abort_n, start_signal, load_signal, done_table_init, finished_init,
             finished_transaction,
      output random_init, init_memory, load_memory, load_field, field_idx,
             start_transaction, reset_others_n, global_reset_n, txn_timeout, state_code
   );
endinterface

// File: rtl/txn_sequencer.sv
// rtl/txn_sequencer.sv - coin-transfer game control FSM: init, N field loads, transaction, timed cleanup
// Optional TRANSACT watchdog is built only when TXN_TIMEOUT_EN is defined.
module txn_sequencer #(
   parameter int NUM_FIELDS = 3,
   parameter int FIELD_W    = 2,
   parameter int RST_HOLD   = 3,
   parameter int TIMEOUT    = 1023
) (
   input  logic           clock,
   input  logic           resetn,
   txn_sequencer_if.slave bus
);
   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_LOAD       = 4'd1,
      S_WAIT       = 4'd2,
      S_ARMED      = 4'd3,
      S_TRANSACT   = 4'd4,
      S_CLEANUP    = 4'd5,
      S_INIT_TABLE = 4'd6,
      S_INIT_MEM   = 4'd7,
      S_STARTUP    = 4'd8
   } state_t;

   localparam int                  HOLD_W     = $clog2(RST_HOLD + 1);
   localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(RST_HOLD - 1);
   localparam logic [HOLD_W-1:0]   HOLD_MAX   = HOLD_W'(RST_HOLD);
   localparam logic [FIELD_W-1:0]  LAST_FIELD = FIELD_W'(NUM_FIELDS - 1);

   state_t              state_q, state_d;
   logic [FIELD_W-1:0]  field_q, field_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                timeout_fire;

`ifdef TXN_TIMEOUT_EN
   localparam int                TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_q;

   // Counter sits at zero outside TRANSACT, so every entry starts a fresh count.
   always_comb begin
      to_cnt_d = '0;
      if (state_q == S_TRANSACT && to_cnt_q != TO_LAST)
         to_cnt_d = to_cnt_q + TO_W'(1);
   end

   assign timeout_fire = (state_q == S_TRANSACT) && (to_cnt_q == TO_LAST)
                         && !bus.finished_transaction;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_fire && bus.abort_n;
      end
   end

   assign bus.txn_timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT > 0);
   assign timeout_fire       = 1'b0;
   assign bus.txn_timeout    = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      field_d = field_q;
      hold_d  = '0;
      if (!bus.abort_n) begin
         state_d = S_CLEANUP;
         field_d = '0;
      end else begin
         case (state_q)
            S_STARTUP:    if (bus.start_signal) state_d = S_INIT_TABLE;
            S_INIT_TABLE: if (bus.done_table_init) state_d = S_INIT_MEM;
            S_INIT_MEM: begin
               if (bus.finished_init) begin
                  state_d = S_CLEANUP;
                  field_d = '0;
               end
            end
            S_IDLE: begin
               if (bus.load_signal) begin
                  state_d = S_LOAD;
                  field_d = '0;
               end
            end
            // Release of the button is the handshake that commits the field.
            S_LOAD: begin
               if (!bus.load_signal)
                  state_d = (field_q == LAST_FIELD) ? S_ARMED : S_WAIT;
            end
            S_WAIT: begin
               if (bus.load_signal) begin
                  state_d = S_LOAD;
                  field_d = field_q + FIELD_W'(1);
               end
            end
            S_ARMED:      if (bus.start_signal) state_d = S_TRANSACT;
            S_TRANSACT: begin
               if (bus.finished_transaction || timeout_fire) begin
                  state_d = S_CLEANUP;
                  field_d = '0;
               end
            end
            S_CLEANUP: begin
               if (hold_q == HOLD_LAST)
                  state_d = S_IDLE;
               else
                  hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
            end
            default:      state_d = S_STARTUP;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q <= S_STARTUP;
         field_q <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
         hold_q  <= hold_d;
      end
   end

   assign bus.random_init       = (state_q == S_INIT_TABLE);
   assign bus.init_memory       = (state_q == S_INIT_MEM);
   assign bus.load_memory       = (state_q == S_IDLE);
   assign bus.load_field        = (state_q == S_LOAD) ? (NUM_FIELDS'(1) << field_q) : '0;
   assign bus.field_idx         = field_q;
   assign bus.start_transaction = (state_q == S_TRANSACT);
   assign bus.reset_others_n    = (state_q != S_CLEANUP);
   assign bus.global_reset_n    = (state_q != S_STARTUP);
   assign bus.state_code        = state_q;
endmodule

// File: tb/tb_txn_sequencer.sv
// tb/tb_txn_sequencer.sv - randomized scenario bench for txn_sequencer (NUM_FIELDS=3, RST_HOLD=3, TIMEOUT=8)
module tb_txn_sequencer;
   localparam int NF   = 3;
   localparam int HOLD = 3;
   localparam int TO   = 8;

   logic clock;
   logic resetn;
   int   total = 0;
   int   bad   = 0;

   txn_sequencer_if #(.NUM_FIELDS(NF), .FIELD_W(2)) bus ();

   txn_sequencer #(.NUM_FIELDS(NF), .FIELD_W(2), .RST_HOLD(HOLD), .TIMEOUT(TO)) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Counts consecutive CLEANUP observations (reset_others_n low) and leaves the bench in the next state.
   task automatic run_cleanup(output int n);
      n = 0;
      while (bus.state_code == 4'd5 && bus.reset_others_n == 1'b0 && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic drive_to_armed();
      for (int k = 0; k < NF; k++) begin
         bus.load_signal = 1'b1; tick();
         bus.load_signal = 1'b0; tick();
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.abort_n = 1'b1;
      bus.start_signal = 1'($urandom);
      bus.load_signal = 1'($urandom);
      tick();
      total++; if (bus.state_code !== 4'd8) begin bad++; $display("FAIL reset_code got=%0d want=8", bus.state_code); end
      total++; if (bus.global_reset_n !== 1'b0) begin bad++; $display("FAIL reset_global got=%0b want=0", bus.global_reset_n); end
      total++; if (bus.reset_others_n !== 1'b1) begin bad++; $display("FAIL reset_others got=%0b want=1", bus.reset_others_n); end
      total++;
      if ({bus.random_init, bus.init_memory, bus.load_memory, bus.load_field, bus.field_idx,
           bus.start_transaction, bus.txn_timeout} !== '0) begin
         bad++; $display("FAIL reset_outputs got=%0h want=0", {bus.random_init, bus.init_memory,
            bus.load_memory, bus.load_field, bus.field_idx, bus.start_transaction, bus.txn_timeout});
      end
      bus.start_signal = 1'b0;
      bus.load_signal  = 1'b0;
      resetn = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      total++; if (bus.state_code !== 4'd8) begin bad++; $display("FAIL startup_hold got=%0d want=8", bus.state_code); end
   endtask

   task automatic test_init();
      int n;
      bus.start_signal = 1'b1; tick(); bus.start_signal = 1'b0;
      total++; if (bus.state_code !== 4'd6 || bus.random_init !== 1'b1 || bus.global_reset_n !== 1'b1) begin
         bad++; $display("FAIL init_table got=%0d/%0b want=6/1", bus.state_code, bus.random_init); end
      repeat ($urandom_range(0, 3)) tick();
      total++; if (bus.state_code !== 4'd6) begin bad++; $display("FAIL init_table_wait got=%0d want=6", bus.state_code); end
      bus.done_table_init = 1'b1; tick(); bus.done_table_init = 1'b0;
      total++; if (bus.state_code !== 4'd7 || bus.init_memory !== 1'b1) begin
         bad++; $display("FAIL init_mem got=%0d/%0b want=7/1", bus.state_code, bus.init_memory); end
      bus.finished_init = 1'b1; tick(); bus.finished_init = 1'b0;
      run_cleanup(n);
      total++; if (n !== HOLD) begin bad++; $display("FAIL init_cleanup_len got=%0d want=%0d", n, HOLD); end
      total++; if (bus.state_code !== 4'd0 || bus.load_memory !== 1'b1) begin
         bad++; $display("FAIL init_idle got=%0d/%0b want=0/1", bus.state_code, bus.load_memory); end
   endtask

   task automatic test_load_fields(input int rounds);
      int n;
      logic [NF-1:0] exp_lf;
      for (int r = 0; r < rounds; r++) begin
         for (int k = 0; k < NF; k++) begin
            bus.load_signal  = 1'b1;
            bus.start_signal = (k == 0) ? 1'($urandom) : 1'b0;
            tick();
            bus.start_signal = 1'b0;
            exp_lf = NF'(1) << k;
            total++; if (bus.state_code !== 4'd1 || bus.load_field !== exp_lf || bus.field_idx !== 2'(k)) begin
               bad++; $display("FAIL load_press r=%0d k=%0d got=%0d/%b/%0d want=1/%b/%0d", r, k,
                  bus.state_code, bus.load_field, bus.field_idx, exp_lf, k); end
            repeat ($urandom_range(0, 3)) tick();
            total++; if (bus.state_code !== 4'd1 || bus.field_idx !== 2'(k)) begin
               bad++; $display("FAIL load_held r=%0d k=%0d got=%0d/%0d want=1/%0d", r, k, bus.state_code, bus.field_idx, k); end
            bus.load_signal = 1'b0;
            tick();
            total++; if (bus.state_code !== ((k == NF - 1) ? 4'd3 : 4'd2) || bus.field_idx !== 2'(k)) begin
               bad++; $display("FAIL load_release r=%0d k=%0d got=%0d/%0d want=%0d/%0d", r, k, bus.state_code,
                  bus.field_idx, (k == NF - 1) ? 3 : 2, k); end
            if (k < NF - 1) repeat ($urandom_range(0, 3)) tick();
         end
         repeat ($urandom_range(1, 3)) begin
            bus.load_signal = 1'($urandom); tick();
         end
         bus.load_signal = 1'b0;
         total++; if (bus.state_code !== 4'd3) begin bad++; $display("FAIL armed_ignore_load got=%0d want=3", bus.state_code); end
         bus.start_signal = 1'b1; tick(); bus.start_signal = 1'b0;
         total++; if (bus.state_code !== 4'd4 || bus.start_transaction !== 1'b1) begin
            bad++; $display("FAIL transact got=%0d/%0b want=4/1", bus.state_code, bus.start_transaction); end
         repeat ($urandom_range(0, 5)) tick();
         bus.finished_transaction = 1'b1; tick(); bus.finished_transaction = 1'b0;
         total++; if (bus.state_code !== 4'd5 || bus.field_idx !== 2'd0 || bus.txn_timeout !== 1'b0) begin
            bad++; $display("FAIL txn_done got=%0d/%0d/%0b want=5/0/0", bus.state_code, bus.field_idx, bus.txn_timeout); end
         run_cleanup(n);
         total++; if (n !== HOLD || bus.state_code !== 4'd0 || bus.field_idx !== 2'd0) begin
            bad++; $display("FAIL txn_cleanup got=%0d/%0d/%0d want=%0d/0/0", n, bus.state_code, bus.field_idx, HOLD); end
      end
   endtask

   task automatic test_abort();
      int n;
      for (int k = 0; k < 2; k++) begin
         bus.load_signal = 1'b1; tick();
         bus.load_signal = 1'b0; tick();
      end
      total++; if (bus.state_code !== 4'd2 || bus.field_idx !== 2'd1) begin
         bad++; $display("FAIL abort_setup got=%0d/%0d want=2/1", bus.state_code, bus.field_idx); end
      bus.abort_n = 1'b0; tick(); bus.abort_n = 1'b1;
      total++; if (bus.state_code !== 4'd5 || bus.field_idx !== 2'd0) begin
         bad++; $display("FAIL abort_cleanup got=%0d/%0d want=5/0", bus.state_code, bus.field_idx); end
      tick();
      bus.abort_n = 1'b0; tick(); bus.abort_n = 1'b1;
      run_cleanup(n);
      total++; if (n !== HOLD || bus.state_code !== 4'd0) begin
         bad++; $display("FAIL abort_restart got=%0d/%0d want=%0d/0", n, bus.state_code, HOLD); end
      bus.load_signal = 1'b1; tick();
      bus.abort_n = 1'b0; resetn = 1'b0; tick();
      bus.abort_n = 1'b1; resetn = 1'b1; bus.load_signal = 1'b0;
      total++; if (bus.state_code !== 4'd8 || bus.global_reset_n !== 1'b0) begin
         bad++; $display("FAIL abort_vs_reset got=%0d/%0b want=8/0", bus.state_code, bus.global_reset_n); end
      bus.start_signal = 1'b1; tick(); bus.start_signal = 1'b0;
      bus.done_table_init = 1'b1; tick(); bus.done_table_init = 1'b0;
      bus.finished_init = 1'b1; tick(); bus.finished_init = 1'b0;
      run_cleanup(n);
      total++; if (bus.state_code !== 4'd0) begin bad++; $display("FAIL reinit got=%0d want=0", bus.state_code); end
   endtask

   task automatic test_timeout();
      int n;
      int odd;
      drive_to_armed();
      bus.start_signal = 1'b1; tick(); bus.start_signal = 1'b0;
`ifdef TXN_TIMEOUT_EN
      n = 0;
      while (bus.state_code == 4'd4 && n < 50) begin n++; tick(); end
      total++; if (n !== TO || bus.state_code !== 4'd5 || bus.txn_timeout !== 1'b1) begin
         bad++; $display("FAIL timeout_fire got=%0d/%0d/%0b want=%0d/5/1", n, bus.state_code, bus.txn_timeout, TO); end
      tick();
      total++; if (bus.txn_timeout !== 1'b0) begin bad++; $display("FAIL timeout_pulse_width got=%0b want=0", bus.txn_timeout); end
      run_cleanup(n);
      total++; if (n !== HOLD - 1 || bus.state_code !== 4'd0) begin
         bad++; $display("FAIL timeout_cleanup got=%0d/%0d want=%0d/0", n, bus.state_code, HOLD - 1); end
      drive_to_armed();
      bus.start_signal = 1'b1; tick(); bus.start_signal = 1'b0;
      repeat (TO - 1) tick();
      bus.finished_transaction = 1'b1; tick(); bus.finished_transaction = 1'b0;
      total++; if (bus.state_code !== 4'd5 || bus.txn_timeout !== 1'b0) begin
         bad++; $display("FAIL timeout_tie got=%0d/%0b want=5/0", bus.state_code, bus.txn_timeout); end
      run_cleanup(n);
`else
      odd = 0;
      repeat (100) begin
         if (bus.state_code !== 4'd4 || bus.txn_timeout !== 1'b0) odd++;
         tick();
      end
      total++; if (odd !== 0) begin bad++; $display("FAIL no_timeout got=%0d want=0", odd); end
      bus.finished_transaction = 1'b1; tick(); bus.finished_transaction = 1'b0;
      run_cleanup(n);
      total++; if (n !== HOLD || bus.state_code !== 4'd0) begin
         bad++; $display("FAIL late_finish got=%0d/%0d want=%0d/0", n, bus.state_code, HOLD); end
`endif
   endtask

   initial begin
      resetn = 1'b0;
      bus.abort_n = 1'b1;
      bus.start_signal = 1'b0;
      bus.load_signal = 1'b0;
      bus.done_table_init = 1'b0;
      bus.finished_init = 1'b0;
      bus.finished_transaction = 1'b0;
      test_reset();
      test_init();
      test_load_fields(4);
      test_abort();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end
endmodule
